// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event receiver.
// Scan-code set 2 prefixes, event bundle and frame FSM states.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } frame_state_e;

    // Frame is {stop, parity, data[7:0], start}, start in bit 0.
    function automatic logic frame_ok(input logic [10:0] f);
        return !f[0] && f[10] && (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with occupancy count and drop-on-full pulse.
// A simultaneous push and pop while full both succeed.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     push,
    input  ps2_evt_t                 wdata,
    input  logic                     pop,
    output logic                     valid,
    output ps2_evt_t                 rdata,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    ps2_evt_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          ovf_q;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign full    = (cnt == FULL_CNT);
    assign valid   = (cnt != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge iCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            ovf_q <= push && !do_push;
        end
    end

    assign rdata    = valid ? mem[rd_ptr] : '0;
    assign overflow = ovf_q;
    assign count    = cnt;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: decodes set-2 bytes into make/break key events
// with E0/F0 prefix tracking, buffered in a valid/ready drained FIFO.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int SAMPLE_DIV    = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic                          iPS2_clk,
    input  logic                          iPS2_data,
    output logic                          oEvtValid,
    input  logic                          iEvtReady,
    output logic [7:0]                    oKeyCode,
    output logic                          oExtended,
    output logic                          oBreak,
    output logic                          oFrameErr,
    output logic                          oOverflow,
    output logic [$clog2(FIFO_DEPTH):0]   oFifoCount
);

    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);

    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          fall;

    frame_state_e  state_q, state_d;
    logic [10:0]   sh_q;
    logic [3:0]    bitcnt_q;
    logic [TW-1:0] to_cnt_q;
    logic          shift_en;
    logic          err_d;
    logic          bad_frame;
    logic          byte_ok;
    logic          err_q;

    logic          byte_vld_q;
    logic [7:0]    byte_q;
    logic          ext_pend;
    logic          brk_pend;
    logic          evt_push;
    ps2_evt_t      evt_in;
    ps2_evt_t      head;
    logic          head_vld;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            div_cnt  <= '0;
        end else begin
            clk_s1 <= iPS2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= iPS2_data;
            dat_s2 <= dat_s1;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                clk_prev <= clk_s2;
            end
        end
    end

    assign tick = (div_cnt == DIV_LAST);
    assign fall = tick && clk_prev && !clk_s2;

    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        err_d     = 1'b0;
        bad_frame = 1'b0;
        byte_ok   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    shift_en = 1'b1;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bitcnt_q == 4'd10) begin
                        state_d = CHECK;
                    end
                end else if (tick && to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (frame_ok(sh_q)) begin
                    byte_ok = 1'b1;
                end else begin
                    err_d     = 1'b1;
                    bad_frame = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            bitcnt_q   <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            byte_vld_q <= byte_ok;
            if (byte_ok) begin
                byte_q <= sh_q[8:1];
            end
            if (shift_en) begin
                sh_q     <= {dat_s2, sh_q[10:1]};
                bitcnt_q <= (state_q == IDLE) ? 4'd1 : bitcnt_q + 4'd1;
            end
            // Timeout only runs while a frame is partially received.
            if (state_q != RECV || fall) begin
                to_cnt_q <= '0;
            end else if (tick) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST || bad_frame) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_vld_q) begin
            unique case (1'b1)
                byte_q == PS2_EXT_PREFIX:   ext_pend <= 1'b1;
                byte_q == PS2_BREAK_PREFIX: brk_pend <= 1'b1;
                default: begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            endcase
        end
    end

    assign evt_push = byte_vld_q
                   && byte_q != PS2_EXT_PREFIX
                   && byte_q != PS2_BREAK_PREFIX;
    assign evt_in   = '{ext: ext_pend, brk: brk_pend, code: byte_q};

    ps2_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .push    (evt_push),
        .wdata   (evt_in),
        .pop     (iEvtReady),
        .valid   (head_vld),
        .rdata   (head),
        .overflow(oOverflow),
        .count   (oFifoCount)
    );

    assign oEvtValid = head_vld;
    assign oKeyCode  = head.code;
    assign oExtended = head.ext;
    assign oBreak    = head.brk;
    assign oFrameErr = err_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Scoreboard bench for ps2_key_event_rx: directed PS/2 frames in,
// expected events queued and checked by an independent monitor.
module tb_ps2_key_event_rx;
    import ps2_pkg::*;

    localparam int SDIV  = 4;
    localparam int TOUT  = 40;
    localparam int DEPTH = 8;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iPS2_clk = 1'b1;
    logic       iPS2_data = 1'b1;
    logic       iEvtReady = 1'b0;
    logic       oEvtValid;
    logic [7:0] oKeyCode;
    logic       oExtended;
    logic       oBreak;
    logic       oFrameErr;
    logic       oOverflow;
    logic [3:0] oFifoCount;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int ovf_seen = 0;
    int valid_cycles = 0;
    int exp_err = 0;
    logic [9:0] exp_q[$];

    ps2_key_event_rx #(
        .SAMPLE_DIV(SDIV),
        .TIMEOUT_TICKS(TOUT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iPS2_clk(iPS2_clk),
        .iPS2_data(iPS2_data),
        .oEvtValid(oEvtValid),
        .iEvtReady(iEvtReady),
        .oKeyCode(oKeyCode),
        .oExtended(oExtended),
        .oBreak(oBreak),
        .oFrameErr(oFrameErr),
        .oOverflow(oOverflow),
        .oFifoCount(oFifoCount)
    );

    always #10 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            iPS2_data = f[i];
            cyc(20);
            iPS2_clk = 1'b0;
            cyc(40);
            iPS2_clk = 1'b1;
            cyc(20);
        end
        iPS2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        send_bits(f, 11);
        cyc(40);
    endtask

    always @(negedge iCLK) begin
        if (!iRST) begin
            if (oFrameErr) err_seen++;
            if (oOverflow) ovf_seen++;
            if (oEvtValid) begin
                valid_cycles++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_evt actual=%0h required=none",
                             {oExtended, oBreak, oKeyCode});
                end else begin
                    chk("evt_head", {22'd0, oExtended, oBreak, oKeyCode},
                        {22'd0, exp_q[0]});
                    if (iEvtReady) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        cyc(5);
        chk("rst_valid", {31'd0, oEvtValid}, 0);
        chk("rst_code", {24'd0, oKeyCode}, 0);
        chk("rst_ext_brk", {30'd0, oExtended, oBreak}, 0);
        chk("rst_err_ovf", {30'd0, oFrameErr, oOverflow}, 0);
        chk("rst_count", {28'd0, oFifoCount}, 0);
        iRST = 1'b0;
        iEvtReady = 1'b1;
        cyc(10);

        send_frame(8'hE0, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 8'h74});
        send_frame(8'h74, 1'b0);
        chk("e0_74_valid_cycles", valid_cycles, 1);
        chk("e0_74_no_err", err_seen, 0);
        chk("e0_74_count", {28'd0, oFifoCount}, 0);

        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        exp_q.push_back({1'b1, 1'b1, 8'h6B});
        send_frame(8'h6B, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 8'h1C});
        send_frame(8'h1C, 1'b0);

        send_frame(8'h1C, 1'b1);
        exp_err++;
        chk("parity_err", err_seen, exp_err);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h33, 1'b1);
        exp_err++;
        exp_q.push_back({1'b0, 1'b0, 8'h1C});
        send_frame(8'h1C, 1'b0);
        chk("brk_cleared_err", err_seen, exp_err);

        send_bits(11'h0AA, 5);
        cyc(400);
        exp_err++;
        chk("timeout_err", err_seen, exp_err);
        exp_q.push_back({1'b0, 1'b0, 8'h29});
        send_frame(8'h29, 1'b0);

        iEvtReady = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) exp_q.push_back({2'b00, 8'(8'h15 + k)});
            send_frame(8'(8'h15 + k), 1'b0);
        end
        chk("full_count", {28'd0, oFifoCount}, 8);
        chk("overflow_pulses", ovf_seen, 1);
        for (int k = 0; k < 40; k++) begin
            iEvtReady = k[0];
            cyc(1);
        end
        iEvtReady = 1'b1;
        cyc(4);
        chk("drained_count", {28'd0, oFifoCount}, 0);

        send_bits(11'h3FE, 6);
        iRST = 1'b1;
        cyc(3);
        iRST = 1'b0;
        cyc(400);
        chk("reset_no_err", err_seen, exp_err);
        exp_q.push_back({1'b0, 1'b0, 8'h5A});
        send_frame(8'h5A, 1'b0);

        for (int k = 0; k < 1000 && exp_q.size() != 0; k++) cyc(1);
        chk("queue_empty", exp_q.size(), 0);
        chk("final_err", err_seen, exp_err);
        chk("final_ovf", ovf_seen, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_rx.md
Name: ps2_key_event_rx

Overview:
Parametrised PS/2 keyboard receiver that replaces the fixed two-arrow-key controller. It decodes every scan-code set 2 byte into a key event carrying make/break and extended flags, instead of filtering for left/right arrows. Events are buffered in a small FIFO and drained through a valid/ready handshake by the game/control logic. It sits between the PS/2 pins and the motion/command logic.

Parameters:
SAMPLE_DIV, 250, iCLK cycles per PS/2 sample tick (≥2).
TIMEOUT_TICKS, 4000, sample ticks without a PS/2 falling edge before a partial frame is aborted.
FIFO_DEPTH, 8, event FIFO entries (power of 2, ≥2).

Ports:
iCLK  in  1  system clock; single clock domain.
iRST  in  1  synchronous, active-high reset.
iPS2_clk  in  1  raw PS/2 clock (asynchronous).
iPS2_data  in  1  raw PS/2 data (asynchronous).
oEvtValid  out  1  FIFO head holds a valid event.
iEvtReady  in  1  consumer accepts the head event this cycle.
oKeyCode  out  8  scan code of the head event.
oExtended  out  1  head event was prefixed by E0.
oBreak  out  1  head event was prefixed by F0 (key release).
oFrameErr  out  1  1-cycle pulse: bad start/stop/parity or timeout abort.
oOverflow  out  1  1-cycle pulse: event dropped because the FIFO was full.
oFifoCount  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (iRST=1 at a posedge iCLK) sets all outputs to 0. The FIFO empties, the FSM returns to IDLE, the E0/F0 pending flags clear, and the divider and timeout counters zero. The synchronisers' previous-clock register is set to 1. Reset mid-frame discards the partial frame with no error pulse.
- iPS2_clk and iPS2_data each pass through a 2-FF synchroniser.
- The divider counts 0..SAMPLE_DIV-1 and emits a 1-cycle tick on wrap. All PS/2 sampling happens only on ticks.
- A falling edge is detected on a tick when the previous sampled clock is 1 and the current one is 0. Data is shifted in LSB-first on each falling edge.
- Frame FSM:
  - IDLE: on a falling edge, capture the start bit, set bitcnt=1, go to RECV.
  - RECV: on each falling edge, shift and increment bitcnt. When bitcnt reaches 11, go to CHECK. The timeout counter increments on each tick with no edge and clears on each edge. When it reaches TIMEOUT_TICKS, pulse oFrameErr and go to IDLE.
  - CHECK (exactly 1 iCLK cycle): the frame is valid iff start=0, stop=1, and odd parity over data+parity. If invalid, pulse oFrameErr, clear the pending flags, go to IDLE. If valid, pass the byte to the decoder and go to IDLE.
- Decoder, on a valid byte:
  - E0: set ext_pend; no event.
  - F0: set brk_pend; no event.
  - Any other byte: push {ext_pend, brk_pend, byte} and clear both flags.
  - E1 and AA are ordinary codes.
- Latency: the push occurs on the cycle after CHECK. oEvtValid rises one cycle after the push.
- FIFO:
  - Pop when oEvtValid && iEvtReady.
  - Head outputs are registered and held stable while valid && !ready.
  - Push when full without a pop: the new event is dropped and oOverflow pulses.
  - Push and pop in the same cycle while full: both succeed; count is unchanged; no overflow.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- oEvtValid, oKeyCode, oExtended and oBreak are 0 when the FIFO is empty.

Decomposition:
- Package ps2_pkg:
  - Constants PS2_EXT_PREFIX=8'hE0 and PS2_BREAK_PREFIX=8'hF0.
  - Typedef ps2_evt_t packed struct {logic ext; logic brk; logic [7:0] code;}.
  - Frame FSM state enum {IDLE, RECV, CHECK}.
- One sub-module, ps2_evt_fifo (parametrised by DEPTH, element ps2_evt_t): synchronous FIFO with count and the overflow/same-cycle rules above.
- Synchroniser, divider, frame FSM and decoder stay in the top module.

Test Plan:
(Params 250/4000/8, iCLK 50 MHz, PS/2 clock 12.5 kHz.)
- Frames 0xE0, 0x74 with iEvtReady=1 -> one event: code=0x74, ext=1, brk=0. Valid for 1 cycle. No oFrameErr.
- Frames 0xE0, 0xF0, 0x6B -> one event: code=0x6B, ext=1, brk=1. A following plain 0x1C -> code=0x1C, ext=0, brk=0 (flags cleared).
- Frame 0x1C with flipped parity -> oFrameErr pulses once, no event. Also: send 0xF0 then a bad frame, then 0x1C -> event with brk=0.
- Send 5 bits, then idle > TIMEOUT_TICKS ticks -> oFrameErr pulse. A subsequent full 0x29 frame -> event code=0x29.
- iEvtReady=0, 9 make codes 0x15..0x1D -> oFifoCount=8, one oOverflow pulse on the 9th. Draining yields 0x15..0x1C in order, with the head stable while stalled.
- Assert iRST after 6 bits of a frame, then send 0x5A -> no error pulse; only event code=0x5A, ext=0, brk=0.
